// File: rtl/simon_game_ctrl.sv
// simon_game_ctrl: game sequencer for the Simon Says design.
// Grows a pseudo-random colour sequence by one entry per round, plays it back
// on the LED outputs, checks the player's presses and reports win or lose.
// Optional build macro: SIMON_TIMEOUT_EN adds an inactivity timeout in INPUT
// (TIMEOUT_CYCLES). Without it INPUT waits indefinitely.
module simon_game_ctrl #(
    parameter int          MAX_LEN        = 16,
    parameter logic [23:0] ON_CYCLES      = 24'd6000000,
    parameter logic [23:0] OFF_CYCLES     = 24'd3000000,
    parameter logic [27:0] TIMEOUT_CYCLES = 28'd100000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       btn_valid,
    input  logic [1:0] btn_colour,
    output logic       led_on,
    output logic [1:0] led_colour,
    output logic [4:0] level,
    output logic       input_phase,
    output logic       game_win,
    output logic       game_over
);

`ifdef SIMON_TIMEOUT_EN
    localparam int TW = 28;
`else
    localparam int TW = 24;
    // TIMEOUT_CYCLES has no function in this build.
    logic unused_timeout_s;
    assign unused_timeout_s = ^TIMEOUT_CYCLES;
`endif

    localparam logic [TW-1:0] TIMER_ONE = TW'(1);
    localparam logic [TW-1:0] ON_LAST   = TW'(ON_CYCLES - 24'd1);
    localparam logic [TW-1:0] OFF_LAST  = TW'(OFF_CYCLES - 24'd1);
`ifdef SIMON_TIMEOUT_EN
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 28'd1);
`endif
    localparam logic [4:0]    MAX_LEVEL = 5'(MAX_LEN);
    localparam logic [15:0]   LFSR_SEED = 16'hACE1;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_GEN      = 3'd1,
        S_SHOW_ON  = 3'd2,
        S_SHOW_OFF = 3'd3,
        S_INPUT    = 3'd4,
        S_WIN      = 3'd5,
        S_LOSE     = 3'd6
    } state_t;

    state_t         state_r;
    logic [31:0]    seq_r;
    logic [3:0]     idx_r;
    logic [TW-1:0]  timer_r;
    logic [15:0]    lfsr_r;
    logic           led_on_r;
    logic [1:0]     led_colour_r;
    logic [4:0]     level_r;
    logic           input_phase_r;
    logic           game_win_r;
    logic           game_over_r;

    logic [3:0]     idx_inc_s;
    logic           idx_last_s;
    logic [1:0]     cur_colour_s;
    logic [1:0]     next_colour_s;

    // 16-bit Fibonacci LFSR step, taps 16,14,13,11; feedback enters at bit 0.
    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    assign idx_inc_s     = idx_r + 4'd1;
    assign idx_last_s    = (({1'b0, idx_r} + 5'd1) == level_r);
    assign cur_colour_s  = seq_r[{idx_r, 1'b0} +: 2];
    assign next_colour_s = seq_r[{idx_inc_s, 1'b0} +: 2];

    assign led_on      = led_on_r;
    assign led_colour  = led_colour_r;
    assign level       = level_r;
    assign input_phase = input_phase_r;
    assign game_win    = game_win_r;
    assign game_over   = game_over_r;

    // Game sequencer: state, sequence store, counters, LFSR and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= S_IDLE;
            seq_r         <= 32'd0;
            idx_r         <= 4'd0;
            timer_r       <= '0;
            lfsr_r        <= LFSR_SEED;
            led_on_r      <= 1'b0;
            led_colour_r  <= 2'd0;
            level_r       <= 5'd0;
            input_phase_r <= 1'b0;
            game_win_r    <= 1'b0;
            game_over_r   <= 1'b0;
        end else begin
            lfsr_r <= lfsr_next(lfsr_r);
            case (state_r)
                S_IDLE: begin
                    timer_r <= '0;
                    if (start) begin
                        state_r <= S_GEN;
                        level_r <= 5'd0;
                        seq_r   <= 32'd0;
                    end else begin
                        state_r <= S_IDLE;
                    end
                end

                S_GEN: begin
                    seq_r[{level_r[3:0], 1'b0} +: 2] <= lfsr_r[1:0];
                    level_r  <= level_r + 5'd1;
                    idx_r    <= 4'd0;
                    timer_r  <= '0;
                    state_r  <= S_SHOW_ON;
                    led_on_r <= 1'b1;
                    // Entry 0 is being written this cycle on the first round.
                    led_colour_r <= (level_r == 5'd0) ? lfsr_r[1:0] : seq_r[1:0];
                end

                S_SHOW_ON: begin
                    if (timer_r == ON_LAST) begin
                        timer_r  <= '0;
                        state_r  <= S_SHOW_OFF;
                        led_on_r <= 1'b0;
                    end else begin
                        timer_r <= timer_r + TIMER_ONE;
                    end
                end

                S_SHOW_OFF: begin
                    if (timer_r == OFF_LAST) begin
                        timer_r <= '0;
                        if (idx_last_s) begin
                            idx_r         <= 4'd0;
                            state_r       <= S_INPUT;
                            input_phase_r <= 1'b1;
                        end else begin
                            idx_r        <= idx_inc_s;
                            state_r      <= S_SHOW_ON;
                            led_on_r     <= 1'b1;
                            led_colour_r <= next_colour_s;
                        end
                    end else begin
                        timer_r <= timer_r + TIMER_ONE;
                    end
                end

                S_INPUT: begin
                    if (btn_valid) begin
                        timer_r <= '0;
                        if (btn_colour != cur_colour_s) begin
                            state_r       <= S_LOSE;
                            game_over_r   <= 1'b1;
                            input_phase_r <= 1'b0;
                        end else if (idx_last_s) begin
                            input_phase_r <= 1'b0;
                            if (level_r == MAX_LEVEL) begin
                                state_r    <= S_WIN;
                                game_win_r <= 1'b1;
                            end else begin
                                state_r <= S_GEN;
                            end
                        end else begin
                            idx_r <= idx_inc_s;
                        end
                    end
`ifdef SIMON_TIMEOUT_EN
                    else if (timer_r == TO_LAST) begin
                        timer_r       <= '0;
                        state_r       <= S_LOSE;
                        game_over_r   <= 1'b1;
                        input_phase_r <= 1'b0;
                    end else begin
                        timer_r <= timer_r + TIMER_ONE;
                    end
`else
                    else begin
                        timer_r <= '0;
                    end
`endif
                end

                S_WIN, S_LOSE: begin
                    timer_r <= '0;
                    if (start) begin
                        state_r     <= S_GEN;
                        level_r     <= 5'd0;
                        seq_r       <= 32'd0;
                        game_win_r  <= 1'b0;
                        game_over_r <= 1'b0;
                    end else begin
                        state_r <= state_r;
                    end
                end

                default: begin
                    state_r       <= S_IDLE;
                    timer_r       <= '0;
                    led_on_r      <= 1'b0;
                    input_phase_r <= 1'b0;
                    game_win_r    <= 1'b0;
                    game_over_r   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_simon_game_ctrl.sv
// tb_simon_game_ctrl: directed self-checking bench for simon_game_ctrl.
// Runs with MAX_LEN=3, ON=2, OFF=1, TIMEOUT=5 so whole games fit in a few
// hundred cycles. Expected colours come from a reference LFSR kept in the
// bench, clocked and reset alongside the design.
module tb_simon_game_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic       btn_valid;
    logic [1:0] btn_colour;
    logic       led_on;
    logic [1:0] led_colour;
    logic [4:0] level;
    logic       input_phase;
    logic       game_win;
    logic       game_over;

    int n_checks = 0;
    int n_pass   = 0;

    logic [15:0] m_lfsr;
    logic [1:0]  exp_seq [0:2];

    simon_game_ctrl #(
        .MAX_LEN        (3),
        .ON_CYCLES      (24'd2),
        .OFF_CYCLES     (24'd1),
        .TIMEOUT_CYCLES (28'd5)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .btn_valid   (btn_valid),
        .btn_colour  (btn_colour),
        .led_on      (led_on),
        .led_colour  (led_colour),
        .level       (level),
        .input_phase (input_phase),
        .game_win    (game_win),
        .game_over   (game_over)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference LFSR: seed on reset, Fibonacci taps 16,14,13,11 otherwise.
    always @(posedge clk) begin
        if (rst) m_lfsr <= 16'hACE1;
        else     m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called in the first SHOW_ON cycle; checks n entries (2 on, 1 off each)
    // and ends in the first INPUT cycle. With noise, wrong-colour presses are
    // pulsed on every playback cycle and must be ignored.
    task automatic play(input int n, input bit noise);
        for (int i = 0; i < n; i++) begin
            for (int c = 0; c < 2; c++) begin
                check_eq($sformatf("show_on_led_e%0d_c%0d", i, c), led_on, 1);
                check_eq($sformatf("show_on_col_e%0d_c%0d", i, c), led_colour, exp_seq[i]);
                check_eq($sformatf("show_on_inph_e%0d_c%0d", i, c), input_phase, 0);
                if (noise) begin
                    btn_valid  = 1'b1;
                    btn_colour = ~exp_seq[i];
                end
                step();
                btn_valid = 1'b0;
            end
            check_eq($sformatf("show_off_led_e%0d", i), led_on, 0);
            check_eq($sformatf("show_off_inph_e%0d", i), input_phase, 0);
            if (noise) begin
                btn_valid  = 1'b1;
                btn_colour = ~exp_seq[i];
            end
            step();
            btn_valid = 1'b0;
        end
        check_eq($sformatf("input_phase_after_%0d", n), input_phase, 1);
        check_eq($sformatf("input_led_after_%0d", n), led_on, 0);
    endtask

    task automatic press(input logic [1:0] c);
        btn_valid  = 1'b1;
        btn_colour = c;
        step();
        btn_valid  = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        btn_valid  = 1'b0;
        btn_colour = 2'd0;
        step();
        step();
        check_eq("rst_led_on", led_on, 0);
        check_eq("rst_led_colour", led_colour, 0);
        check_eq("rst_level", level, 0);
        check_eq("rst_input_phase", input_phase, 0);
        check_eq("rst_game_win", game_win, 0);
        check_eq("rst_game_over", game_over, 0);

        // Presses in IDLE are ignored. Five idle cycles put the LFSR six
        // shifts past the seed at GEN: 0x3879, so entry 0 = 2'b01.
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            btn_valid  = 1'b1;
            btn_colour = k[1:0];
            step();
        end
        btn_valid = 1'b0;
        check_eq("idle_btn_level", level, 0);
        check_eq("idle_btn_inph", input_phase, 0);
        check_eq("idle_btn_over", game_over, 0);

        start = 1'b1;
        step();                       // GEN
        exp_seq[0] = m_lfsr[1:0];
        check_eq("gen0_level", level, 0);
        check_eq("gen0_led", led_on, 0);
        start = 1'b0;
        step();                       // SHOW_ON
        check_eq("r1_level", level, 1);
        play(1, 1'b0);

        // Round 1 correct -> GEN, entry 1 taken from the LFSR now.
        press(exp_seq[0]);
        exp_seq[1] = m_lfsr[1:0];
        check_eq("r1_gen_inph", input_phase, 0);
        check_eq("r1_gen_level", level, 1);
        step();
        check_eq("r2_level", level, 2);
        play(2, 1'b1);

        // Round 2: first press right, second wrong -> LOSE.
        press(exp_seq[0]);
        check_eq("r2_mid_inph", input_phase, 1);
        check_eq("r2_mid_over", game_over, 0);
        press(~exp_seq[1]);
        check_eq("lose_over", game_over, 1);
        check_eq("lose_level", level, 2);
        check_eq("lose_led", led_on, 0);
        check_eq("lose_inph", input_phase, 0);
        btn_valid  = 1'b1;
        btn_colour = exp_seq[0];
        step();
        step();
        btn_valid = 1'b0;
        check_eq("lose_btn_over", game_over, 1);
        check_eq("lose_btn_level", level, 2);

        // Restart from LOSE, then win a full 3-round game.
        start = 1'b1;
        step();                       // GEN
        exp_seq[0] = m_lfsr[1:0];
        check_eq("restart_over", game_over, 0);
        check_eq("restart_level", level, 0);
        start = 1'b0;
        step();
        check_eq("restart_r1_level", level, 1);
        play(1, 1'b0);
        press(exp_seq[0]);
        exp_seq[1] = m_lfsr[1:0];
        step();
        play(2, 1'b0);
        press(exp_seq[0]);
        press(exp_seq[1]);
        exp_seq[2] = m_lfsr[1:0];
        step();
        check_eq("w_r3_level", level, 3);
        play(3, 1'b0);
        press(exp_seq[0]);
        press(exp_seq[1]);
        check_eq("w_r3_mid_win", game_win, 0);
        press(exp_seq[2]);
        check_eq("win_flag", game_win, 1);
        check_eq("win_level", level, 3);
        check_eq("win_inph", input_phase, 0);
        check_eq("win_led", led_on, 0);
        check_eq("win_over", game_over, 0);

        // Restart from WIN.
        start = 1'b1;
        step();
        exp_seq[0] = m_lfsr[1:0];
        check_eq("win_restart_flag", game_win, 0);
        check_eq("win_restart_level", level, 0);
        start = 1'b0;
        step();
        play(1, 1'b0);                // INPUT cycle 1

`ifdef SIMON_TIMEOUT_EN
        // Press on cycle 5 of INPUT beats the timeout.
        repeat (4) step();
        check_eq("to_pre_press_inph", input_phase, 1);
        press(exp_seq[0]);
        exp_seq[1] = m_lfsr[1:0];
        check_eq("to_press_over", game_over, 0);
        check_eq("to_press_inph", input_phase, 0);
        step();
        check_eq("to_r2_level", level, 2);
        play(2, 1'b0);                // INPUT cycle 1
        repeat (4) step();            // cycle 5, no press
        check_eq("to_c5_over", game_over, 0);
        check_eq("to_c5_inph", input_phase, 1);
        step();
        check_eq("to_lose_over", game_over, 1);
        check_eq("to_lose_inph", input_phase, 0);
        check_eq("to_lose_level", level, 2);
        start = 1'b1;
        step();
        start = 1'b0;
        step();                       // SHOW_ON
`else
        // Without the timeout INPUT waits indefinitely.
        repeat (20) step();
        check_eq("wait_inph", input_phase, 1);
        check_eq("wait_over", game_over, 0);
        press(exp_seq[0]);
        step();                       // SHOW_ON
        check_eq("wait_r2_level", level, 2);
`endif

        // Reset mid-playback.
        check_eq("pre_rst_led", led_on, 1);
        rst = 1'b1;
        step();
        check_eq("mid_rst_led", led_on, 0);
        check_eq("mid_rst_colour", led_colour, 0);
        check_eq("mid_rst_level", level, 0);
        check_eq("mid_rst_inph", input_phase, 0);
        check_eq("mid_rst_win", game_win, 0);
        check_eq("mid_rst_over", game_over, 0);
        rst = 1'b0;
        step();
        step();
        check_eq("post_rst_idle_led", led_on, 0);
        check_eq("post_rst_idle_level", level, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
